dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the MIPS core's load/store path and a debug/DMA port (program loader, memory inspection). It sits between `mips_core`'s memory stage and `data_mem`, issues at most one memory access per cycle, returns read data one cycle later tagged to the owner, and stalls the core while the debug port holds the memory. A wait counter bounds debug starvation under continuous core traffic.

## Interface
- `ADDR_W`, 32, byte-address width on both requester ports
- `DATA_W`, 32, data word width
- `MEM_AW`, 8, word-index width on memory side (`addr[MEM_AW+1:2]`)
- `MAX_WAIT`, 8, cycles the debug port may wait before forced grant (1..255)
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `core_req`, `core_we`  in  1  core access request / write enable
- `core_addr`  in  ADDR_W  core byte address
- `core_wdata`  in  DATA_W  core store data
- `core_gnt`  out  1  access issued this cycle
- `core_stall`  out  1  `core_req & ~core_gnt`
- `core_rvalid`  out  1  core read data valid
- `core_rdata`  out  DATA_W  core read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same as core set, debug side
- `err_misalign`  out  1  one-cycle pulse: granted request had `addr[1:0] != 0`
- `mem_en`, `mem_we`  out  1  memory access strobe / write
- `mem_addr`  out  MEM_AW  word index
- `mem_wdata`  out  DATA_W  write data
- `mem_rdata`  in  DATA_W  synchronous read data, valid one cycle after `mem_en & ~mem_we`

## Operation
- Requester holds `req/we/addr/wdata` stable until `gnt`; `gnt` is combinational from inputs plus registered state.
- Arbitration per cycle: if `force_dbg` (wait count == `MAX_WAIT`) and `dbg_req` -> debug; else core has priority; else debug.
- Granted request drives `mem_*` the same cycle; only the winner's `gnt` is high.
- Misaligned granted request: `gnt` still asserts (requester released), `mem_en`=0, `err_misalign`=1, no rvalid follows.
- Read grant sets registered `rd_pend` and `rd_owner`; next cycle the owner's `rvalid`=1 and `rdata`=`mem_rdata`; other port's `rdata` is 0.
- Writes produce no rvalid.
- Wait counter (8 bit): increments each cycle `dbg_req & ~dbg_gnt`, saturates at `MAX_WAIT`; clears on `dbg_gnt` or `~dbg_req`.
- States: IDLE (no pending read), RD_CORE, RD_DBG. From any state: grant read -> RD_<owner>; otherwise -> IDLE. Back-to-back reads allowed (one per cycle, fully pipelined).

## Timing
- Reset values: all `gnt`, `rvalid`, `stall`, `err_misalign`, `mem_en`, `mem_we` = 0; `rdata`, `mem_addr`, `mem_wdata` = 0; counter 0; state IDLE.
- Reset asserted mid-read: pending response dropped, no rvalid after release.
- Grant latency: 0 cycles uncontended; debug worst case `MAX_WAIT` cycles.
- Read latency: rvalid exactly 1 cycle after grant.
- Simultaneous requests without force: core wins, debug counter increments.
- Forced grant stalls core exactly one cycle; counter clears.
- `mem_wdata` = winner's wdata on writes, 0 otherwise.

## Structure
- Shared package `mips_pkg`: owner encoding (`OWN_CORE`=0, `OWN_DBG`=1), FSM state enum, default widths.
- No sub-module; single file with one comb arbitration block and one sequential block.
- Instantiated inside `mips_core` between load/store path and `data_mem`; debug port tied off (req=0) when unused.

## Test plan
- Core SW 123 to addr 0x4, then LW addr 0x4 -> `mem_addr`=1, `core_rvalid`=1 one cycle after LW grant, `core_rdata`=123.
- Debug write 0xDEADBEEF to addr 0x10 with core idle -> `dbg_gnt` same cycle; later core LW 0x10 returns 0xDEADBEEF.
- Core and debug request every cycle, `MAX_WAIT`=4 -> debug granted on 5th cycle, `core_stall`=1 for that cycle only, counter back to 0.
- Interleaved reads core 0x0 / debug 0x8 back-to-back -> each rvalid on correct port only, data not crossed.
- Core LW addr 0x6 -> `err_misalign` pulse, `mem_en`=0, no `core_rvalid`.
- Read granted, `rst` low before next edge -> no rvalid after release, all outputs 0.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS data-memory path: default port widths,
// requester owner encoding and the arbiter read-pipeline state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MEM_AW_DEF   = 8;
    localparam int MAX_WAIT_DEF = 8;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_CORE = 2'd1,
        ST_RD_DBG  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the core load/store path and the
// debug/DMA port. One access per cycle, core has priority unless the debug
// port has waited MAX_WAIT cycles. Read data comes back one cycle after the
// grant on the owning port only.
//
// Ports
//   clk, rst                         clock, async active-low reset
//   core_req/we/addr/wdata           core request (held until core_gnt)
//   core_gnt/stall/rvalid/rdata      core grant, stall, read response
//   dbg_req/we/addr/wdata            debug request (held until dbg_gnt)
//   dbg_gnt/rvalid/rdata             debug grant, read response
//   err_misalign                     granted request had addr[1:0] != 0
//   mem_en/we/addr/wdata, mem_rdata  synchronous single-port memory
//
// State | meaning
// ------+-----------------------------------------------
// IDLE  | no read in flight
// RD_CORE | read issued last cycle, response goes to core
// RD_DBG  | read issued last cycle, response goes to debug
// -----------------------------------------------------------------------------
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MEM_AW   = MEM_AW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              err_misalign,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    arb_state_t        state, state_nxt;
    logic [7:0]        wait_cnt, wait_nxt;
    logic              force_dbg;
    logic              win_core, win_dbg, granted, misalign;
    logic              owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Only the word index and alignment bits of the byte address matter.
    logic unused_addr_bits;
    assign unused_addr_bits = ^sel_addr[ADDR_W-1:MEM_AW+2];

    always_comb begin
        force_dbg = (wait_cnt == WAIT_LIM);

        // Grants are held off while reset is asserted so every output reads 0.
        win_core = 1'b0;
        win_dbg  = 1'b0;
        if (rst) begin
            if (force_dbg && dbg_req) begin
                win_dbg = 1'b1;
            end else if (core_req) begin
                win_core = 1'b1;
            end else if (dbg_req) begin
                win_dbg = 1'b1;
            end
        end

        owner     = win_dbg ? OWN_DBG : OWN_CORE;
        sel_we    = (owner == OWN_DBG) ? dbg_we    : core_we;
        sel_addr  = (owner == OWN_DBG) ? dbg_addr  : core_addr;
        sel_wdata = (owner == OWN_DBG) ? dbg_wdata : core_wdata;

        granted  = win_core | win_dbg;
        misalign = granted && (sel_addr[1:0] != 2'b00);

        // A misaligned request is still granted (releasing the requester)
        // but never reaches the memory.
        core_gnt     = win_core;
        dbg_gnt      = win_dbg;
        core_stall   = rst & core_req & ~win_core;
        err_misalign = misalign;
        mem_en       = granted & ~misalign;
        mem_we       = mem_en & sel_we;
        mem_addr     = mem_en ? sel_addr[MEM_AW+1:2] : '0;
        mem_wdata    = mem_we ? sel_wdata : '0;

        core_rvalid = (state == ST_RD_CORE);
        dbg_rvalid  = (state == ST_RD_DBG);
        core_rdata  = core_rvalid ? mem_rdata : '0;
        dbg_rdata   = dbg_rvalid  ? mem_rdata : '0;

        state_nxt = ST_IDLE;
        if (mem_en && !mem_we) begin
            state_nxt = (owner == OWN_DBG) ? ST_RD_DBG : ST_RD_CORE;
        end

        if (!dbg_req || win_dbg) begin
            wait_nxt = 8'd0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_nxt = wait_cnt + 8'd1;
        end else begin
            wait_nxt = wait_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

endmodule
